// File: rtl/riscv_issue_scheduler_pkg.sv
// Shared definitions for the issue scheduler: register index width, FSM encodings
// and the decoded slot bundle with invalid/unsupported classes folded into csr.
package riscv_defs;

    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 1 << REG_IDX_W;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_SERIAL = 2'd2;

    typedef struct packed {
        logic                 valid;
        logic                 lsu;
        logic                 branch;
        logic                 mul;
        logic                 div;
        logic                 csr;
        logic                 writes_rd;
        logic [REG_IDX_W-1:0] rd;
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
    } slot_t;

    // A slot with no class flag, or a mul/div the core cannot execute, traps through csr.
    function automatic slot_t decode_slot(
        input logic                 valid,
        input logic                 exec,
        input logic                 lsu,
        input logic                 branch,
        input logic                 mul,
        input logic                 div,
        input logic                 csr,
        input logic                 writes_rd,
        input logic [REG_IDX_W-1:0] rd,
        input logic [REG_IDX_W-1:0] rs1,
        input logic [REG_IDX_W-1:0] rs2,
        input logic                 muldiv_en
    );
        slot_t s;
        s.valid     = valid;
        s.lsu       = lsu;
        s.branch    = branch;
        s.mul       = mul & muldiv_en;
        s.div       = div & muldiv_en;
        s.csr       = csr | ((mul | div) & ~muldiv_en)
                    | ~(exec | lsu | branch | mul | div | csr);
        s.writes_rd = writes_rd;
        s.rd        = rd;
        s.rs1       = rs1;
        s.rs2       = rs2;
        return s;
    endfunction

endpackage

// File: rtl/riscv_issue_scheduler_scoreboard.sv
// Pending-writeback mask for long-latency results: two set ports (issue), two clear
// ports (writeback), set wins on collision, x0 never pending.
module riscv_scoreboard
    import riscv_defs::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             set_en,
    input  logic [2*REG_IDX_W-1:0] set_idx,
    input  logic [1:0]             clr_en,
    input  logic [2*REG_IDX_W-1:0] clr_idx,
    input  logic [REG_IDX_W-1:0]   s0_ra,
    input  logic [REG_IDX_W-1:0]   s0_rb,
    input  logic [REG_IDX_W-1:0]   s1_ra,
    input  logic [REG_IDX_W-1:0]   s1_rb,
    output logic                   s0_ra_busy,
    output logic                   s0_rb_busy,
    output logic                   s1_ra_busy,
    output logic                   s1_rb_busy,
    output logic [NUM_REGS-1:0]    pending
);

    logic [NUM_REGS-1:0] pending_next;

    always_comb begin
        pending_next = pending;
        for (int k = 0; k < 2; k++) begin
            if (clr_en[k]) pending_next[clr_idx[k*REG_IDX_W +: REG_IDX_W]] = 1'b0;
        end
        for (int k = 0; k < 2; k++) begin
            if (set_en[k]) pending_next[set_idx[k*REG_IDX_W +: REG_IDX_W]] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= pending_next;
    end

    assign s0_ra_busy = pending[s0_ra];
    assign s0_rb_busy = pending[s0_rb];
    assign s1_ra_busy = pending[s1_ra];
    assign s1_rb_busy = pending[s1_rb];

endmodule

// File: rtl/riscv_issue_scheduler.sv
// Two-slot in-order issue scheduler: scoreboard hazards, divider occupancy and
// csr serialisation through a RUN/DRAIN/SERIAL state machine.
module riscv_issue_scheduler
    import riscv_defs::*;
#(
    parameter int DUAL_ISSUE     = 1,
    parameter int SUPPORT_MULDIV = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   s0_valid_i,
    input  logic                   s0_exec_i,
    input  logic                   s0_lsu_i,
    input  logic                   s0_branch_i,
    input  logic                   s0_mul_i,
    input  logic                   s0_div_i,
    input  logic                   s0_csr_i,
    input  logic                   s0_writes_rd_i,
    input  logic [REG_IDX_W-1:0]   s0_rd_i,
    input  logic [REG_IDX_W-1:0]   s0_rs1_i,
    input  logic [REG_IDX_W-1:0]   s0_rs2_i,
    input  logic                   s1_valid_i,
    input  logic                   s1_exec_i,
    input  logic                   s1_lsu_i,
    input  logic                   s1_branch_i,
    input  logic                   s1_mul_i,
    input  logic                   s1_div_i,
    input  logic                   s1_csr_i,
    input  logic                   s1_writes_rd_i,
    input  logic [REG_IDX_W-1:0]   s1_rd_i,
    input  logic [REG_IDX_W-1:0]   s1_rs1_i,
    input  logic [REG_IDX_W-1:0]   s1_rs2_i,
    input  logic                   stall_i,
    input  logic                   flush_i,
    input  logic [1:0]             wb_valid_i,
    input  logic [2*REG_IDX_W-1:0] wb_rd_i,
    input  logic                   div_done_i,
    input  logic                   csr_done_i,
    output logic                   s0_issue_o,
    output logic                   s1_issue_o,
    output logic                   div_busy_o,
    output logic [NUM_REGS-1:0]    sb_pending_o,
    output logic [1:0]             fsm_state_o
);

    localparam logic MULDIV_EN = (SUPPORT_MULDIV != 0);
    localparam logic DUAL_EN   = (DUAL_ISSUE != 0);

    slot_t s0, s1;
    assign s0 = decode_slot(s0_valid_i, s0_exec_i, s0_lsu_i, s0_branch_i, s0_mul_i, s0_div_i,
                            s0_csr_i, s0_writes_rd_i, s0_rd_i, s0_rs1_i, s0_rs2_i, MULDIV_EN);
    assign s1 = decode_slot(s1_valid_i, s1_exec_i, s1_lsu_i, s1_branch_i, s1_mul_i, s1_div_i,
                            s1_csr_i, s1_writes_rd_i, s1_rd_i, s1_rs1_i, s1_rs2_i, MULDIV_EN);

    logic [1:0]          state, state_next;
    logic                div_busy;
    logic [NUM_REGS-1:0] pending;
    logic                s0_ra_busy, s0_rb_busy, s1_ra_busy, s1_rb_busy;
    logic                s0_ready, s1_ready, quiet, go;
    logic                s0_issue, s1_issue, pair_conflict, raw_hazard;
    logic [1:0]          set_en;

    riscv_scoreboard u_scoreboard (
        .clk        (clk_i),
        .rst_n      (rst_ni),
        .set_en     (set_en),
        .set_idx    ({s1.rd, s0.rd}),
        .clr_en     (wb_valid_i),
        .clr_idx    (wb_rd_i),
        .s0_ra      (s0.rs1),
        .s0_rb      (s0.rs2),
        .s1_ra      (s1.rs1),
        .s1_rb      (s1.rs2),
        .s0_ra_busy (s0_ra_busy),
        .s0_rb_busy (s0_rb_busy),
        .s1_ra_busy (s1_ra_busy),
        .s1_rb_busy (s1_rb_busy),
        .pending    (pending)
    );

    // x0 is never pending, so the rd lookup needs no explicit x0 exclusion.
    assign s0_ready = s0.valid && !s0_ra_busy && !s0_rb_busy && !pending[s0.rd]
                      && !(s0.div && div_busy);
    assign s1_ready = s1.valid && !s1_ra_busy && !s1_rb_busy && !pending[s1.rd]
                      && !(s1.div && div_busy);
    assign quiet    = (pending == '0) && !div_busy;
    assign go       = rst_ni && !stall_i && !flush_i;

    always_comb begin
        s0_issue   = 1'b0;
        state_next = state;
        case (state)
            ST_RUN: begin
                if (s0.valid && s0.csr) begin
                    if (!quiet) begin
                        if (!flush_i) state_next = ST_DRAIN;
                    end else if (go && s0_ready) begin
                        s0_issue   = 1'b1;
                        state_next = ST_SERIAL;
                    end
                end else if (go && s0_ready) begin
                    s0_issue = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (flush_i) begin
                    state_next = ST_RUN;
                end else if (s0.valid && s0.csr && quiet && go && s0_ready) begin
                    s0_issue   = 1'b1;
                    state_next = ST_SERIAL;
                end
            end
            ST_SERIAL: begin
                if (csr_done_i) state_next = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase
    end

    assign pair_conflict = (s0.lsu && s1.lsu) || (s0.mul && s1.mul) || (s0.div && s1.div);
    assign raw_hazard    = s0.writes_rd && (s0.rd != '0)
                           && ((s0.rd == s1.rs1) || (s0.rd == s1.rs2) || (s0.rd == s1.rd));
    assign s1_issue      = s0_issue && DUAL_EN && s1_ready
                           && !(s0.csr || s1.csr || s0.branch || s1.branch)
                           && !pair_conflict && !raw_hazard;

    assign set_en[0] = s0_issue && ((s0.lsu && s0.writes_rd) || s0.mul || s0.div) && (s0.rd != '0);
    assign set_en[1] = s1_issue && ((s1.lsu && s1.writes_rd) || s1.mul || s1.div) && (s1.rd != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= ST_RUN;
            div_busy <= 1'b0;
        end else begin
            state <= state_next;
            if ((s0_issue && s0.div) || (s1_issue && s1.div)) div_busy <= 1'b1;
            else if (div_done_i)                              div_busy <= 1'b0;
        end
    end

    assign s0_issue_o   = s0_issue;
    assign s1_issue_o   = s1_issue;
    assign div_busy_o   = div_busy;
    assign sb_pending_o = pending;
    assign fsm_state_o  = state;

endmodule

// File: tb/tb_riscv_issue_scheduler.sv
// Directed scenarios followed by randomized traffic, each cycle checked against a
// behavioural model of the issue rules (pending-register set, divider flag, csr mode).
module tb_riscv_issue_scheduler;
    import riscv_defs::*;

    typedef struct packed {
        bit       valid, exec, lsu, branch, mul, div, csr, wr;
        bit [4:0] rd, rs1, rs2;
    } ins_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    ins_t        s0, s1;
    logic        stall, flush, div_done, csr_done;
    logic [1:0]  wb_valid;
    logic [9:0]  wb_rd;
    logic        s0_issue, s1_issue, div_busy;
    logic [31:0] sb_pending;
    logic [1:0]  fsm_state;

    int errors = 0;
    int checks = 0;
    logic obs0, obs1;

    // reference model state
    bit         m_pend[32];
    bit         m_div_busy;
    logic [1:0] m_mode;

    always #5 clk = ~clk;

    riscv_issue_scheduler dut (
        .clk_i(clk), .rst_ni(rst_n),
        .s0_valid_i(s0.valid), .s0_exec_i(s0.exec), .s0_lsu_i(s0.lsu), .s0_branch_i(s0.branch),
        .s0_mul_i(s0.mul), .s0_div_i(s0.div), .s0_csr_i(s0.csr), .s0_writes_rd_i(s0.wr),
        .s0_rd_i(s0.rd), .s0_rs1_i(s0.rs1), .s0_rs2_i(s0.rs2),
        .s1_valid_i(s1.valid), .s1_exec_i(s1.exec), .s1_lsu_i(s1.lsu), .s1_branch_i(s1.branch),
        .s1_mul_i(s1.mul), .s1_div_i(s1.div), .s1_csr_i(s1.csr), .s1_writes_rd_i(s1.wr),
        .s1_rd_i(s1.rd), .s1_rs1_i(s1.rs1), .s1_rs2_i(s1.rs2),
        .stall_i(stall), .flush_i(flush), .wb_valid_i(wb_valid), .wb_rd_i(wb_rd),
        .div_done_i(div_done), .csr_done_i(csr_done),
        .s0_issue_o(s0_issue), .s1_issue_o(s1_issue), .div_busy_o(div_busy),
        .sb_pending_o(sb_pending), .fsm_state_o(fsm_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ins_t mk(input string cls, input bit wr, input bit [4:0] rd,
                                input bit [4:0] rs1, input bit [4:0] rs2);
        ins_t x;
        x = '0;
        x.valid = 1'b1;
        case (cls)
            "exec":   x.exec = 1'b1;
            "lsu":    x.lsu = 1'b1;
            "branch": x.branch = 1'b1;
            "mul":    x.mul = 1'b1;
            "div":    x.div = 1'b1;
            "csr":    x.csr = 1'b1;
            default:  ;
        endcase
        x.wr = wr; x.rd = rd; x.rs1 = rs1; x.rs2 = rs2;
        return x;
    endfunction

    function automatic ins_t rnd_ins();
        ins_t  x;
        int    p;
        string cls;
        p = $urandom_range(0, 99);
        if (p < 35)      cls = "exec";
        else if (p < 60) cls = "lsu";
        else if (p < 70) cls = "branch";
        else if (p < 80) cls = "mul";
        else if (p < 88) cls = "div";
        else if (p < 95) cls = "csr";
        else             cls = "none";
        x = mk(cls, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        x.valid = ($urandom_range(0, 5) != 0);
        return x;
    endfunction

    // ---------------- reference model ----------------
    function automatic bit is_trap(input ins_t x);
        return x.csr || !(x.exec || x.lsu || x.branch || x.mul || x.div || x.csr);
    endfunction

    function automatic bit regs_free(input ins_t x);
        bit [4:0] r[3];
        r = '{x.rs1, x.rs2, x.rd};
        foreach (r[i]) if (r[i] != 0 && m_pend[r[i]]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit can_go(input ins_t x);
        return x.valid && regs_free(x) && !(x.div && m_div_busy);
    endfunction

    function automatic logic [31:0] model_mask();
        logic [31:0] m;
        for (int i = 0; i < 32; i++) m[i] = m_pend[i];
        return m;
    endfunction

    function automatic void model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_div_busy = 1'b0;
        m_mode = ST_RUN;
    endfunction

    function automatic void model_eval(output bit e0, output bit e1, output logic [1:0] nm);
        bit quiet, blocked, clash;
        quiet   = (model_mask() == 0) && !m_div_busy;
        blocked = stall || flush || !rst_n;
        e0 = 1'b0; e1 = 1'b0; nm = m_mode;
        if (m_mode == ST_SERIAL) begin
            if (csr_done) nm = ST_RUN;
        end else if (m_mode == ST_DRAIN && flush) begin
            nm = ST_RUN;
        end else if (s0.valid && is_trap(s0)) begin
            if (quiet) begin
                if (!blocked && can_go(s0)) begin e0 = 1'b1; nm = ST_SERIAL; end
            end else if (m_mode == ST_RUN && !flush) begin
                nm = ST_DRAIN;
            end
        end else if (m_mode == ST_RUN) begin
            e0 = !blocked && can_go(s0);
        end
        clash = (s0.lsu && s1.lsu) || (s0.mul && s1.mul) || (s0.div && s1.div)
             || (s0.wr && s0.rd != 0 && (s0.rd == s1.rs1 || s0.rd == s1.rs2 || s0.rd == s1.rd));
        e1 = e0 && can_go(s1) && !is_trap(s0) && !is_trap(s1)
             && !s0.branch && !s1.branch && !clash;
    endfunction

    function automatic void mark(input ins_t x);
        if (((x.lsu && x.wr) || x.mul || x.div) && x.rd != 0) m_pend[x.rd] = 1'b1;
    endfunction

    function automatic void model_commit(input bit e0, input bit e1, input logic [1:0] nm);
        for (int k = 0; k < 2; k++) if (wb_valid[k]) m_pend[wb_rd[k*5 +: 5]] = 1'b0;
        if (e0) mark(s0);
        if (e1) mark(s1);
        if ((e0 && s0.div) || (e1 && s1.div)) m_div_busy = 1'b1;
        else if (div_done)                    m_div_busy = 1'b0;
        m_mode = nm;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle();
        s0 = '0; s1 = '0; stall = 0; flush = 0; div_done = 0; csr_done = 0;
        wb_valid = '0; wb_rd = '0;
    endtask

    // Entered just after a falling edge with inputs already driven; leaves on the next one.
    task automatic cycle();
        bit e0, e1;
        logic [1:0] nm;
        #2;
        model_eval(e0, e1, nm);
        obs0 = s0_issue; obs1 = s1_issue;
        check("s0_issue", obs0, e0);
        check("s1_issue", obs1, e1);
        @(posedge clk);
        model_commit(e0, e1, nm);
        #1;
        check("sb_pending", sb_pending, model_mask());
        check("div_busy", div_busy, m_div_busy);
        check("fsm_state", fsm_state, m_mode);
        @(negedge clk);
    endtask

    task automatic async_reset(input string tag);
        s0 = mk("exec", 1, 1, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check({tag, "_sb"}, sb_pending, 32'h0);
        check({tag, "_state"}, fsm_state, ST_RUN);
        check({tag, "_div_busy"}, div_busy, 1'b0);
        check({tag, "_issue"}, {s0_issue, s1_issue}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
    endtask

    initial begin
        idle();
        model_reset();
        s0 = mk("exec", 1, 1, 0, 0);
        s1 = mk("exec", 1, 2, 0, 0);
        repeat (2) @(negedge clk);
        check("rst_issue", {s0_issue, s1_issue}, 2'b00);
        check("rst_sb", sb_pending, 32'h0);
        check("rst_div_busy", div_busy, 1'b0);
        check("rst_state", fsm_state, ST_RUN);
        rst_n = 1'b1;
        idle();

        // add x1 + lw x2 dual issue
        s0 = mk("exec", 1, 1, 0, 0); s1 = mk("lsu", 1, 2, 0, 0);
        cycle();
        check("dual_issue", {obs0, obs1}, 2'b11);
        check("dual_sb", sb_pending, 32'h4);
        idle(); wb_valid = 2'b01; wb_rd = {5'd0, 5'd2};
        cycle();

        // addi x3 ; add x4,x3,x5 -> RAW inside the pair
        idle(); s0 = mk("exec", 1, 3, 0, 0); s1 = mk("exec", 1, 4, 3, 5);
        cycle();
        check("raw_pair", {obs0, obs1}, 2'b10);

        // lw x6 then dependent add x7,x6,x0
        idle(); s0 = mk("lsu", 1, 6, 1, 0);
        cycle();
        check("lw_x6_sb", sb_pending, 32'h40);
        s0 = mk("exec", 1, 7, 6, 0);
        cycle(); check("dep_stall_a", obs0, 1'b0);
        cycle(); check("dep_stall_b", obs0, 1'b0);
        wb_valid = 2'b01; wb_rd = {5'd0, 5'd6};
        cycle(); check("dep_wb_cycle", obs0, 1'b0);
        wb_valid = 2'b00;
        cycle(); check("dep_issue", obs0, 1'b1);
        check("dep_sb_clear", sb_pending, 32'h0);

        // div x8 then div x9 blocked until div_done
        idle(); s0 = mk("div", 1, 8, 1, 2);
        cycle(); check("div1_busy", div_busy, 1'b1);
        s0 = mk("div", 1, 9, 1, 2);
        cycle(); check("div2_blocked", obs0, 1'b0);
        div_done = 1'b1;
        cycle(); check("div2_blocked_done", obs0, 1'b0);
        check("div_busy_fall", div_busy, 1'b0);
        div_done = 1'b0;
        cycle(); check("div2_issue", obs0, 1'b1);
        check("div2_sb", sb_pending, 32'h300);
        idle(); wb_valid = 2'b11; wb_rd = {5'd9, 5'd8}; div_done = 1'b1;
        cycle();

        // mul x10 in flight, csrrw drains then serialises
        idle(); s0 = mk("mul", 1, 10, 1, 2);
        cycle();
        s0 = mk("csr", 0, 0, 0, 0); s1 = mk("exec", 1, 12, 0, 0);
        cycle(); check("csr_drain_noissue", {obs0, obs1}, 2'b00);
        check("csr_drain_state", fsm_state, ST_DRAIN);
        cycle();
        wb_valid = 2'b01; wb_rd = {5'd0, 5'd10};
        cycle(); check("csr_wb_cycle", obs0, 1'b0);
        wb_valid = 2'b00;
        cycle(); check("csr_alone", {obs0, obs1}, 2'b10);
        check("csr_serial", fsm_state, ST_SERIAL);
        idle(); flush = 1'b1;
        cycle(); check("serial_ignores_flush", fsm_state, ST_SERIAL);
        flush = 1'b0; csr_done = 1'b1;
        cycle(); check("serial_done", fsm_state, ST_RUN);

        // same-cycle stray writeback and new lw x11: set wins
        idle(); s0 = mk("lsu", 1, 11, 0, 0); wb_valid = 2'b10; wb_rd = {5'd11, 5'd0};
        cycle(); check("set_beats_clear", sb_pending, 32'h800);
        idle(); s0 = mk("csr", 0, 0, 0, 0);
        cycle(); check("drain_before_rst", fsm_state, ST_DRAIN);
        async_reset("rst_drain");
        s0 = mk("csr", 0, 0, 0, 0);
        cycle(); check("serial_before_rst", fsm_state, ST_SERIAL);
        idle();
        cycle();
        async_reset("rst_serial");

        // randomized traffic
        for (int n = 0; n < 500; n++) begin
            s0 = rnd_ins();
            s1 = rnd_ins();
            stall    = ($urandom_range(0, 9) == 0);
            flush    = ($urandom_range(0, 19) == 0);
            div_done = m_div_busy && ($urandom_range(0, 4) == 0);
            csr_done = (m_mode == ST_SERIAL) && ($urandom_range(0, 2) == 0);
            wb_valid[0] = ($urandom_range(0, 2) == 0);
            wb_valid[1] = ($urandom_range(0, 3) == 0);
            wb_rd = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/riscv_issue_scheduler.md
RISCV_ISSUE_SCHEDULER -- requirements
Module: riscv_issue_scheduler

Interface
REQ-001 SHALL have parameter DUAL_ISSUE, default 1, meaning slot 1 may issue; 0 forces single issue.
REQ-002 SHALL have parameter SUPPORT_MULDIV, default 1, meaning mul/div classes may issue; 0 blocks them.
REQ-003 SHALL have port clk_i  input  1  the single clock, with all state on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports sN_valid_i  input  1  slot N (N=0,1) holds a fetched instruction.
REQ-006 SHALL have ports sN_exec_i, sN_lsu_i, sN_branch_i, sN_mul_i, sN_div_i, sN_csr_i  input  1 each  decoder class flags; csr includes invalid/fault.
REQ-007 SHALL have ports sN_writes_rd_i  input  1; sN_rd_i, sN_rs1_i, sN_rs2_i  input  5 each.
REQ-008 SHALL have ports stall_i  input  1 (backend stall) and flush_i  input  1 (pipeline redirect).
REQ-009 SHALL have ports wb_valid_i  input  2 and wb_rd_i  input  10  two long-latency writeback ports, 5 bits each.
REQ-010 SHALL have ports div_done_i  input  1 and csr_done_i  input  1.
REQ-011 SHALL have ports sN_issue_o  output  1 (slot N issued this cycle) and div_busy_o  output  1.
REQ-012 SHALL have port sb_pending_o  output  32  scoreboard mask.

Function
REQ-013 SHALL make the issue decision combinationally in the same cycle as sN_valid_i, with zero-cycle latency.
REQ-014 SHALL force both issue outputs to 0 while stall_i or flush_i is high.
REQ-015 SHALL issue slot 0 only if it is valid, no rs1/rs2/rd register (excluding x0) is pending in the scoreboard, and its class resource is free.
REQ-016 SHALL issue slot 1 only if slot 0 issues, DUAL_ISSUE=1, slot 1 meets REQ-015, and neither slot is csr or branch.
REQ-017 SHALL block slot 1 when both slots are lsu, both are mul, or both are div.
REQ-018 SHALL block slot 1 when slot 0 writes_rd, rd0!=0, and rd0 equals rs1_1, rs2_1 or rd_1.
REQ-019 SHALL set a scoreboard bit on issue of lsu-with-writes_rd, mul, or div with rd!=0; bit 0 SHALL never be set.
REQ-020 SHALL clear scoreboard bit r when wb_valid_i[k] is high and wb_rd_i[5k+4:5k]==r.
REQ-021 SHALL give set priority over clear when a set and a clear hit the same bit in the same cycle.
REQ-022 SHALL not modify the scoreboard or div_busy on flush_i, because in-flight ops still write back.
REQ-023 SHALL set div_busy on div issue and clear it on the cycle after div_done_i; div SHALL not issue while div_busy.
REQ-024 SHALL implement FSM states RUN, DRAIN, SERIAL.
REQ-025 SHALL in RUN go to DRAIN when slot 0 is valid csr and (scoreboard!=0 or div_busy), with no issue that cycle.
REQ-026 SHALL in RUN issue a valid csr in slot 0 alone and go to SERIAL when the scoreboard is 0 and div is not busy.
REQ-027 SHALL in DRAIN issue nothing until the scoreboard is 0 and div is not busy, then issue slot 0 csr and go to SERIAL.
REQ-028 SHALL in DRAIN return to RUN on flush_i.
REQ-029 SHALL in SERIAL issue nothing and return to RUN on csr_done_i.
REQ-030 SHALL in SERIAL ignore flush_i, because the csr unit owns the redirect.
REQ-031 SHALL treat mul/div flags as invalid when SUPPORT_MULDIV=0: never issue them, and route them as csr to trap.

Reset
REQ-032 SHALL on rst_ni low, asynchronously: scoreboard=0, div_busy=0, FSM=RUN.
REQ-033 SHALL hold sN_issue_o at 0 while rst_ni is low.
REQ-034 SHALL on reset mid-operation discard pending DRAIN/SERIAL state without waiting for csr_done_i.

Structure
REQ-035 SHALL place FSM state encodings and the register-index width constant in the shared riscv_defs package.
REQ-036 SHALL contain one sub-module riscv_scoreboard holding the 32-bit set/clear mask with two read-check ports per slot.

Verification
REQ-037 SHALL cover: s0 add x1 (exec) and s1 lw x2 -> both issue; sb_pending_o=0x4 next cycle.
REQ-038 SHALL cover: s0 addi x3, s1 add x4,x3,x5 -> s0_issue=1, s1_issue=0.
REQ-039 SHALL cover: lw x6 issued, then add x7,x6,x0 -> stall until wb_valid[0] with rd 6; issue the cycle after the clear, sb=0.
REQ-040 SHALL cover: div x8 issued, then div x9 -> blocked; div_done_i pulse -> div_busy_o falls the next cycle, second div issues that cycle.
REQ-041 SHALL cover: mul x10 in flight, then csrrw in s0 -> DRAIN, no issue; writeback of rd 10 -> csr issues alone, SERIAL; csr_done_i -> RUN.
REQ-042 SHALL cover: wb clear and new lw issue to x11 in the same cycle -> bit 11 remains set; rst_ni low in SERIAL -> RUN, sb=0.
